msrh_l1d_rd_arbiter: RTL and testbench

Shares the single L1D read port (`l1d_rd_if`) among `REQ_NUM` requesters: load pipes, the STQ and LRQ eviction. Each cycle it grants at most one s0 request. Priority order is high-priority (`h_pri`), then starved requesters, then round-robin. The granted requester index is registered, and the s1 response (`hit`, `miss`, `conflict`, `data`, replace info) is routed back to that requester one cycle later. The block sits inside the LSU, between the requester pipelines and the L1D data array.

---
 rtl/msrh_lsu_pkg.sv | 25 ++
 rtl/l1d_rd_if.sv | 29 ++
 rtl/msrh_rr_select.sv | 29 ++
 rtl/msrh_l1d_rd_arbiter.sv | 147 ++++++++++++++
 tb/tb_msrh_l1d_rd_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/msrh_lsu_pkg.sv
// Shared LSU definitions: L1D geometry, read-port requester numbering and
// the grant-source encoding used by the L1D read arbiter.
package msrh_lsu_pkg;

    localparam int PADDR_W        = 32;
    localparam int DCACHE_DATA_W  = 64;
    localparam int DCACHE_WAYS    = 4;
    localparam int L1D_RD_REQ_NUM = 4;

    typedef logic [$clog2(L1D_RD_REQ_NUM)-1:0] l1d_rd_req_idx_t;

    // Lower index wins the fixed-priority tie-breaks, so eviction comes first.
    localparam l1d_rd_req_idx_t L1D_RD_REQ_EVICT   = l1d_rd_req_idx_t'(0);
    localparam l1d_rd_req_idx_t L1D_RD_REQ_STQ     = l1d_rd_req_idx_t'(1);
    localparam l1d_rd_req_idx_t L1D_RD_REQ_LDPIPE0 = l1d_rd_req_idx_t'(2);
    localparam l1d_rd_req_idx_t L1D_RD_REQ_LDPIPE1 = l1d_rd_req_idx_t'(3);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_HPRI,
        GRANT_STARVE,
        GRANT_RR
    } grant_src_e;

endpackage

// File: rtl/l1d_rd_if.sv
// L1D read port: s0 request from the arbiter, s1 lookup result from the array.
interface l1d_rd_if;
    import msrh_lsu_pkg::*;

    logic                     s0_valid;
    logic                     s0_h_pri;
    logic [PADDR_W-1:0]       s0_paddr;
    logic                     s1_hit;
    logic                     s1_miss;
    logic                     s1_conflict;
    logic [DCACHE_DATA_W-1:0] s1_data;
    logic                     s1_replace_valid;
    logic [DCACHE_WAYS-1:0]   s1_replace_way;
    logic [DCACHE_DATA_W-1:0] s1_replace_data;
    logic [PADDR_W-1:0]       s1_replace_paddr;

    modport master (
        output s0_valid, s0_h_pri, s0_paddr,
        input  s1_hit, s1_miss, s1_conflict, s1_data,
        input  s1_replace_valid, s1_replace_way, s1_replace_data, s1_replace_paddr
    );

    modport slave (
        input  s0_valid, s0_h_pri, s0_paddr,
        output s1_hit, s1_miss, s1_conflict, s1_data,
        output s1_replace_valid, s1_replace_way, s1_replace_data, s1_replace_paddr
    );

endinterface

// File: rtl/msrh_rr_select.sv
// Combinational round-robin pick: first valid bit at or after i_ptr, wrapping.
// With i_ptr tied to zero it degenerates to a lowest-index priority pick.
module msrh_rr_select #(
    parameter  int WIDTH = 4,
    localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
)(
    input  logic [WIDTH-1:0] i_valid,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [WIDTH-1:0] o_grant_oh,
    output logic [PTR_W-1:0] o_grant_idx
);

    logic [WIDTH-1:0] upper_valid;
    logic [WIDTH-1:0] pick_src;

    // Prefer requests at or above the pointer; fall back to the wrapped lower part.
    always_comb begin
        upper_valid = i_valid & ({WIDTH{1'b1}} << i_ptr);
        pick_src    = (|upper_valid) ? upper_valid : i_valid;
        o_grant_oh  = pick_src & (~pick_src + WIDTH'(1));
        o_grant_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (o_grant_oh[i]) begin
                o_grant_idx = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/msrh_l1d_rd_arbiter.sv
// Arbitrates the single L1D read port among LSU requesters (h_pri, then
// starved, then round-robin) and routes the s1 result back to the winner.
module msrh_l1d_rd_arbiter
    import msrh_lsu_pkg::*;
#(
    parameter int REQ_NUM      = L1D_RD_REQ_NUM,
    parameter int STARVE_LIMIT = 8
)(
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [REQ_NUM-1:0]              i_req_valid,
    input  logic [REQ_NUM-1:0][PADDR_W-1:0] i_req_paddr,
    input  logic [REQ_NUM-1:0]              i_req_h_pri,
    output logic [REQ_NUM-1:0]              o_req_grant,
    l1d_rd_if.master                        l1d_rd_if,
    output logic [REQ_NUM-1:0]              o_resp_valid,
    output logic                            o_resp_hit,
    output logic                            o_resp_miss,
    output logic                            o_resp_conflict,
    output logic [DCACHE_DATA_W-1:0]        o_resp_data,
    output logic                            o_resp_replace_valid,
    output logic [DCACHE_WAYS-1:0]          o_resp_replace_way,
    output logic [DCACHE_DATA_W-1:0]        o_resp_replace_data,
    output logic [PADDR_W-1:0]              o_resp_replace_paddr
);

    localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    logic [CNT_W-1:0]   starve_cnt [REQ_NUM];
    logic [REQ_NUM-1:0] s1_grant_oh;

    logic [REQ_NUM-1:0] hpri_req;
    logic [REQ_NUM-1:0] starved_req;
    logic [REQ_NUM-1:0] hpri_oh;
    logic [REQ_NUM-1:0] starve_oh;
    logic [REQ_NUM-1:0] rr_oh;
    logic [PTR_W-1:0]   hpri_idx;
    logic [PTR_W-1:0]   starve_idx;
    logic [PTR_W-1:0]   rr_idx;
    logic [PTR_W-1:0]   grant_idx;
    grant_src_e         grant_src;
    logic [PADDR_W-1:0] s0_paddr;
    logic               s0_h_pri;

    always_comb begin
        hpri_req = i_req_valid & i_req_h_pri;
        for (int i = 0; i < REQ_NUM; i++) begin
            starved_req[i] = i_req_valid[i] && (starve_cnt[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    msrh_rr_select #(.WIDTH(REQ_NUM)) u_hpri_sel (
        .i_valid     (hpri_req),
        .i_ptr       ('0),
        .o_grant_oh  (hpri_oh),
        .o_grant_idx (hpri_idx)
    );

    msrh_rr_select #(.WIDTH(REQ_NUM)) u_starve_sel (
        .i_valid     (starved_req),
        .i_ptr       ('0),
        .o_grant_oh  (starve_oh),
        .o_grant_idx (starve_idx)
    );

    msrh_rr_select #(.WIDTH(REQ_NUM)) u_rr_sel (
        .i_valid     (i_req_valid),
        .i_ptr       (rr_ptr),
        .o_grant_oh  (rr_oh),
        .o_grant_idx (rr_idx)
    );

    // No grant may leak onto the L1D port while reset is held.
    always_comb begin
        grant_src   = GRANT_NONE;
        o_req_grant = '0;
        grant_idx   = '0;
        if (!i_reset_n) begin
            grant_src = GRANT_NONE;
        end else if (|hpri_req) begin
            grant_src   = GRANT_HPRI;
            o_req_grant = hpri_oh;
            grant_idx   = hpri_idx;
        end else if (|starved_req) begin
            grant_src   = GRANT_STARVE;
            o_req_grant = starve_oh;
            grant_idx   = starve_idx;
        end else if (|i_req_valid) begin
            grant_src   = GRANT_RR;
            o_req_grant = rr_oh;
            grant_idx   = rr_idx;
        end
        rr_next = (grant_idx == PTR_W'(REQ_NUM - 1)) ? '0 : grant_idx + PTR_W'(1);
    end

    always_comb begin
        s0_paddr = '0;
        s0_h_pri = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (o_req_grant[i]) begin
                s0_paddr = s0_paddr | i_req_paddr[i];
                s0_h_pri = s0_h_pri | i_req_h_pri[i];
            end
        end
    end

    // h_pri grants bypass the pointer so eviction swaps do not disturb fairness.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rr_ptr      <= '0;
            s1_grant_oh <= '0;
            for (int i = 0; i < REQ_NUM; i++) begin
                starve_cnt[i] <= '0;
            end
        end else begin
            s1_grant_oh <= o_req_grant;
            if (grant_src == GRANT_STARVE || grant_src == GRANT_RR) begin
                rr_ptr <= rr_next;
            end
            for (int i = 0; i < REQ_NUM; i++) begin
                if (o_req_grant[i] || !i_req_valid[i]) begin
                    starve_cnt[i] <= '0;
                end else if (starve_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
                    starve_cnt[i] <= starve_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign l1d_rd_if.s0_valid = |o_req_grant;
    assign l1d_rd_if.s0_paddr = s0_paddr;
    assign l1d_rd_if.s0_h_pri = s0_h_pri;

    assign o_resp_valid         = s1_grant_oh;
    assign o_resp_hit           = l1d_rd_if.s1_hit;
    assign o_resp_miss          = l1d_rd_if.s1_miss;
    assign o_resp_conflict      = l1d_rd_if.s1_conflict;
    assign o_resp_data          = l1d_rd_if.s1_data;
    assign o_resp_replace_valid = l1d_rd_if.s1_replace_valid;
    assign o_resp_replace_way   = l1d_rd_if.s1_replace_way;
    assign o_resp_replace_data  = l1d_rd_if.s1_replace_data;
    assign o_resp_replace_paddr = l1d_rd_if.s1_replace_paddr;

endmodule

// File: tb/tb_msrh_l1d_rd_arbiter.sv
// Directed bench for msrh_l1d_rd_arbiter (REQ_NUM=4, STARVE_LIMIT=3): vector
// table for arbitration order plus hand sequences for response routing and reset.
module tb_msrh_l1d_rd_arbiter;
    import msrh_lsu_pkg::*;

    localparam int N = 4;

    logic                      i_clk;
    logic                      i_reset_n;
    logic [N-1:0]              i_req_valid;
    logic [N-1:0][PADDR_W-1:0] i_req_paddr;
    logic [N-1:0]              i_req_h_pri;
    logic [N-1:0]              o_req_grant;
    logic [N-1:0]              o_resp_valid;
    logic                      o_resp_hit;
    logic                      o_resp_miss;
    logic                      o_resp_conflict;
    logic [DCACHE_DATA_W-1:0]  o_resp_data;
    logic                      o_resp_replace_valid;
    logic [DCACHE_WAYS-1:0]    o_resp_replace_way;
    logic [DCACHE_DATA_W-1:0]  o_resp_replace_data;
    logic [PADDR_W-1:0]        o_resp_replace_paddr;

    int errors;
    int checks;

    l1d_rd_if rd_if ();

    msrh_l1d_rd_arbiter #(.REQ_NUM(N), .STARVE_LIMIT(3)) dut (
        .i_clk                (i_clk),
        .i_reset_n            (i_reset_n),
        .i_req_valid          (i_req_valid),
        .i_req_paddr          (i_req_paddr),
        .i_req_h_pri          (i_req_h_pri),
        .o_req_grant          (o_req_grant),
        .l1d_rd_if            (rd_if),
        .o_resp_valid         (o_resp_valid),
        .o_resp_hit           (o_resp_hit),
        .o_resp_miss          (o_resp_miss),
        .o_resp_conflict      (o_resp_conflict),
        .o_resp_data          (o_resp_data),
        .o_resp_replace_valid (o_resp_replace_valid),
        .o_resp_replace_way   (o_resp_replace_way),
        .o_resp_replace_data  (o_resp_replace_data),
        .o_resp_replace_paddr (o_resp_replace_paddr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] h_pri;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_resp;
    } vec_t;

    vec_t vecs [20];

    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] h_pri);
        @(negedge i_clk);
        i_req_valid = valid;
        i_req_h_pri = h_pri;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [PADDR_W-1:0] baseAddr(input int k);
        return 32'h1000_0000 + PADDR_W'(k) * 32'h100;
    endfunction

    initial begin
        logic [PADDR_W-1:0] exp_paddr;
        logic [63:0]        pattern_a;

        errors = 0;
        checks = 0;
        pattern_a = 64'hA5A5_1234_5678_C3C3;

        // Expected arbitration sequence worked out by hand for STARVE_LIMIT=3.
        vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0001};
        vecs[2]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0010};
        vecs[3]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0100};
        vecs[4]  = '{4'b1111, 4'b0000, 4'b0001, 4'b1000};
        vecs[5]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0001};
        vecs[6]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0010};
        vecs[7]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0100};
        vecs[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1000};
        vecs[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[10] = '{4'b1010, 4'b1000, 4'b1000, 4'b0000};
        vecs[11] = '{4'b1010, 4'b0000, 4'b0010, 4'b1000};
        vecs[12] = '{4'b1000, 4'b0000, 4'b1000, 4'b0010};
        vecs[13] = '{4'b0101, 4'b0001, 4'b0001, 4'b1000};
        vecs[14] = '{4'b0101, 4'b0001, 4'b0001, 4'b0001};
        vecs[15] = '{4'b0101, 4'b0001, 4'b0001, 4'b0001};
        vecs[16] = '{4'b0101, 4'b0001, 4'b0001, 4'b0001};
        vecs[17] = '{4'b0111, 4'b0000, 4'b0100, 4'b0001};
        vecs[18] = '{4'b0111, 4'b0000, 4'b0001, 4'b0100};
        vecs[19] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};

        for (int k = 0; k < N; k++) begin
            i_req_paddr[k] = baseAddr(k);
        end
        rd_if.s1_hit           = 1'b0;
        rd_if.s1_miss          = 1'b0;
        rd_if.s1_conflict      = 1'b0;
        rd_if.s1_data          = '0;
        rd_if.s1_replace_valid = 1'b0;
        rd_if.s1_replace_way   = '0;
        rd_if.s1_replace_data  = '0;
        rd_if.s1_replace_paddr = '0;

        i_reset_n   = 1'b0;
        i_req_valid = 4'b1111;
        i_req_h_pri = 4'b0000;
        @(negedge i_clk);
        #1;
        checkOutput("reset grant", 64'(o_req_grant), 64'h0);
        checkOutput("reset s0_valid", 64'(rd_if.s0_valid), 64'h0);
        checkOutput("reset resp_valid", 64'(o_resp_valid), 64'h0);
        i_req_valid = 4'b0000;
        @(negedge i_clk);
        i_reset_n = 1'b1;

        for (int v = 0; v < 20; v++) begin
            applyStimulus(vecs[v].valid, vecs[v].h_pri);
            exp_paddr = '0;
            for (int k = 0; k < N; k++) begin
                if (vecs[v].exp_grant[k]) exp_paddr = baseAddr(k);
            end
            checkOutput($sformatf("v%0d grant", v), 64'(o_req_grant), 64'(vecs[v].exp_grant));
            checkOutput($sformatf("v%0d resp_valid", v), 64'(o_resp_valid), 64'(vecs[v].exp_resp));
            checkOutput($sformatf("v%0d s0_valid", v), 64'(rd_if.s0_valid), 64'(|vecs[v].exp_grant));
            checkOutput($sformatf("v%0d s0_h_pri", v), 64'(rd_if.s0_h_pri),
                        64'(|(vecs[v].exp_grant & vecs[v].h_pri)));
            if (vecs[v].exp_grant != '0) begin
                checkOutput($sformatf("v%0d s0_paddr", v), 64'(rd_if.s0_paddr), 64'(exp_paddr));
            end
        end

        // Hit response routed to requester 1 one cycle after its grant.
        i_req_paddr[1] = 32'h8000_0040;
        applyStimulus(4'b0010, 4'b0000);
        checkOutput("pt grant", 64'(o_req_grant), 64'h2);
        checkOutput("pt s0_paddr", 64'(rd_if.s0_paddr), 64'h8000_0040);
        applyStimulus(4'b0000, 4'b0000);
        rd_if.s1_hit           = 1'b1;
        rd_if.s1_data          = pattern_a;
        rd_if.s1_replace_valid = 1'b1;
        rd_if.s1_replace_way   = 4'b0100;
        rd_if.s1_replace_data  = ~pattern_a;
        rd_if.s1_replace_paddr = 32'h8000_1000;
        #1;
        checkOutput("pt resp_valid", 64'(o_resp_valid), 64'h2);
        checkOutput("pt hit", 64'(o_resp_hit), 64'h1);
        checkOutput("pt miss", 64'(o_resp_miss), 64'h0);
        checkOutput("pt conflict", 64'(o_resp_conflict), 64'h0);
        checkOutput("pt data", o_resp_data, pattern_a);
        checkOutput("pt repl_valid", 64'(o_resp_replace_valid), 64'h1);
        checkOutput("pt repl_way", 64'(o_resp_replace_way), 64'h4);
        checkOutput("pt repl_data", o_resp_replace_data, ~pattern_a);
        checkOutput("pt repl_paddr", 64'(o_resp_replace_paddr), 64'h8000_1000);

        // Conflicted lookup is reported, not retried.
        applyStimulus(4'b0010, 4'b0000);
        rd_if.s1_hit           = 1'b0;
        rd_if.s1_replace_valid = 1'b0;
        checkOutput("cf grant", 64'(o_req_grant), 64'h2);
        applyStimulus(4'b0000, 4'b0000);
        rd_if.s1_conflict = 1'b1;
        #1;
        checkOutput("cf resp_valid", 64'(o_resp_valid), 64'h2);
        checkOutput("cf conflict", 64'(o_resp_conflict), 64'h1);
        checkOutput("cf hit", 64'(o_resp_hit), 64'h0);
        rd_if.s1_conflict = 1'b0;

        // Reset while a response is in s1; pointer must come back at 0.
        applyStimulus(4'b0100, 4'b0000);
        checkOutput("rst grant", 64'(o_req_grant), 64'h4);
        @(posedge i_clk);
        #1;
        checkOutput("rst inflight", 64'(o_resp_valid), 64'h4);
        #2;
        i_reset_n = 1'b0;
        #1;
        checkOutput("rst resp_drop", 64'(o_resp_valid), 64'h0);
        checkOutput("rst grant_off", 64'(o_req_grant), 64'h0);
        checkOutput("rst s0_off", 64'(rd_if.s0_valid), 64'h0);
        @(negedge i_clk);
        i_req_valid = 4'b1010;
        #1;
        checkOutput("rst held grant", 64'(o_req_grant), 64'h0);
        i_reset_n = 1'b1;
        #1;
        checkOutput("post-rst grant", 64'(o_req_grant), 64'h2);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("post-rst resp", 64'(o_resp_valid), 64'h2);
        checkOutput("idle s0_valid", 64'(rd_if.s0_valid), 64'h0);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("idle resp", 64'(o_resp_valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
